regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port successor of the single-write, two-read architectural register file in the ARM-style datapath.
- Provides NRD combinational read ports and NWR synchronous write ports, with write-port priority resolution.
- The PC index reads the external `r15` value; writes to it are discarded.
- A post-reset clear sweep zeroes the physical registers one per cycle and signals completion via `ready`.
- Sits between decode (read addresses) and writeback (write ports) of a dual-issue pipeline.

Parameters:
- DATA_W, 32, register width in bits.
- NREGS, 16, architectural register count including PC; must be a power of 2, ≥4.
- NRD, 3, number of read ports.
- NWR, 2, number of write ports.
- PC_IDX, NREGS-1, index mapped to the `r15` input; not physically stored.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- we  in  NWR  per-port write enable.
- wa  in  NWR*AW  packed write addresses, port i at [i*AW +: AW]; AW = $clog2(NREGS).
- wd  in  NWR*DATA_W  packed write data.
- ra  in  NRD*AW  packed read addresses.
- r15  in  DATA_W  value returned for reads of PC_IDX (PC+8).
- rd  out  NRD*DATA_W  packed read data.
- ready  out  1  high once the clear sweep has finished; file accepts writes.

Behaviour:
- Storage: NREGS-1 physical registers (indices 0..NREGS-2). The PC is never stored.
- FSM states: CLEAR, RUN.
- While `reset` is high at an edge:
  - state <= CLEAR, clear counter cnt <= 0, `ready` <= 0.
  - Register contents are unspecified until the sweep completes.
- CLEAR, `reset` low:
  - Each edge writes rf[cnt] <= 0 and increments cnt.
  - On the edge that clears index NREGS-2, state <= RUN and `ready` <= 1.
  - The sweep takes exactly NREGS-1 edges (15 at defaults) after reset deasserts.
- CLEAR handling of other ports:
  - All write enables are ignored.
  - Every rd port outputs 0, including PC_IDX reads.
- `reset` reasserted mid-sweep restarts the sweep from cnt=0.
- RUN: for each port i with we[i]=1 and wa[i]!=PC_IDX, rf[wa[i]] <= wd[i] at the edge.
- Same-cycle write conflict (same address on several enabled ports): the highest port index wins; the other writes are dropped.
- Writes to PC_IDX are silently discarded.
- Reads (RUN) are combinational, zero latency:
  - rd[j] = r15 when ra[j]==PC_IDX.
  - Otherwise rd[j] = rf[ra[j]], the pre-edge value (no bypass unless the optional feature is enabled).
- Reset value of outputs: `ready`=0; rd=0 while in CLEAR.

Optional Feature:
- Macro: REGFILE_MP_BYPASS_EN.
- Enabled: in RUN, a read whose address matches an enabled same-cycle write (not PC_IDX) returns that write's wd combinationally. Highest matching port index wins, consistent with write priority.
- Disabled: reads return the stored pre-edge value; the write becomes visible the cycle after the edge.

Decomposition:
- Package regfile_pkg holds:
  - default constants DATA_W_DEF=32, NREGS_DEF=16;
  - the localparam-style function for AW;
  - typedef enum logic {CLEAR, RUN} rf_state_t.
- One sub-module, regfile_wr_prio: a combinational per-register write-select resolving NWR ports into a single enable and data per register index. Used for both write resolution and bypass selection.

Test Plan:
- Clear sweep: reset high 2 cycles then low → `ready`=0 for exactly 15 edges, then 1; read all ra=0..14 → 0; ra=15 with r15=0x0000_1008 → 0x0000_1008.
- Reset mid-sweep: reassert reset at sweep edge 7 for 1 cycle → `ready` rises 15 edges after the second deassertion, not earlier.
- Dual write: port0 writes R3=0xDEAD_BEEF, port1 writes R4=0x1234_5678 in the same cycle → next cycle rd reads R3 and R4 with those values.
- Conflict: both ports write R5, port0=0x1111_1111 and port1=0x2222_2222 → R5=0x2222_2222.
- PC write and CLEAR writes:
  - we=1, wa=15, wd=0xFFFF_FFFF in RUN → read 15 returns the r15 input; R0..R14 unchanged.
  - writes during CLEAR → ignored; register still 0 after `ready`.
- Bypass: with REGFILE_MP_BYPASS_EN, write R7=0xA5A5_A5A5 and read R7 in the same cycle → rd=0xA5A5_A5A5 before the edge. Without the macro → old value, new value on the next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_pkg                                                  |
// | Description : Shared constants, address-width helper and state type for   |
// |               the multi-port register file.                                |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int NREGS_DEF  = 16;

    function automatic int calc_aw(input int nregs);
        return $clog2(nregs);
    endfunction

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_t;

endpackage
`default_nettype wire

// File: rtl/regfile_wr_prio.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_wr_prio                                              |
// | Description : Resolves NWR write ports into one enable/data pair per       |
// |               stored register; the highest port index wins, PC writes are  |
// |               dropped.                                                     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module regfile_wr_prio
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NWR    = 2,
    parameter int PC_IDX = NREGS - 1,
    parameter int AW     = calc_aw(NREGS)
) (
    input  logic [NWR-1:0]        we_i,
    input  logic [NWR*AW-1:0]     wa_i,
    input  logic [NWR*DATA_W-1:0] wd_i,
    output logic [NREGS-2:0]      en_o,
    output logic [DATA_W-1:0]     data_o [NREGS-1]
);

    localparam logic [AW-1:0] c_PC_IDX = AW'(PC_IDX);

    // Ascending scan: later (higher) ports overwrite earlier ones.
    always_comb begin
        en_o = '0;
        for (int r = 0; r < NREGS - 1; r++) begin
            data_o[r] = '0;
        end
        for (int p = 0; p < NWR; p++) begin
            if (we_i[p] && (wa_i[p*AW +: AW] != c_PC_IDX)) begin
                en_o[wa_i[p*AW +: AW]]   = 1'b1;
                data_o[wa_i[p*AW +: AW]] = wd_i[p*DATA_W +: DATA_W];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_mp                                                   |
// | Description : NRD-read / NWR-write register file with post-reset clear     |
// |               sweep; the PC index reads the r15 input. Define              |
// |               REGFILE_MP_BYPASS_EN for same-cycle write-to-read bypass.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = 3,
    parameter int NWR    = 2,
    parameter int PC_IDX = NREGS - 1,
    localparam int AW    = calc_aw(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NWR-1:0]        we,
    input  logic [NWR*AW-1:0]     wa,
    input  logic [NWR*DATA_W-1:0] wd,
    input  logic [NRD*AW-1:0]     ra,
    input  logic [DATA_W-1:0]     r15,
    output logic [NRD*DATA_W-1:0] rd,
    output logic                  ready
);

    localparam logic [AW-1:0] c_PC_IDX = AW'(PC_IDX);
    localparam logic [AW-1:0] c_LAST   = AW'(NREGS - 2);

    logic [DATA_W-1:0] rf_q [NREGS-1];
    rf_state_t         state_q;
    logic [AW-1:0]     cnt_q;
    logic              ready_q;

    logic [NREGS-2:0]  w_wen;
    logic [DATA_W-1:0] w_wdata [NREGS-1];

    regfile_wr_prio #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .NWR    (NWR),
        .PC_IDX (PC_IDX),
        .AW     (AW)
    ) u_wr_prio (
        .we_i   (we),
        .wa_i   (wa),
        .wd_i   (wd),
        .en_o   (w_wen),
        .data_o (w_wdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    rf_q[cnt_q] <= '0;
                    cnt_q       <= cnt_q + AW'(1);
                    if (cnt_q == c_LAST) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    for (int r = 0; r < NREGS - 1; r++) begin
                        if (w_wen[r]) begin
                            rf_q[r] <= w_wdata[r];
                        end
                    end
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

    assign ready = ready_q;

    for (genvar j = 0; j < NRD; j++) begin : g_rd
        logic [AW-1:0]     w_ra;
        logic [DATA_W-1:0] w_rd;

        assign w_ra = ra[j*AW +: AW];

        // Reads stay zero for the whole sweep, PC index included.
        always_comb begin
            w_rd = '0;
            if (state_q == RUN) begin
                if (w_ra == c_PC_IDX) begin
                    w_rd = r15;
`ifdef REGFILE_MP_BYPASS_EN
                end else if (w_wen[w_ra]) begin
                    w_rd = w_wdata[w_ra];
`endif
                end else begin
                    w_rd = rf_q[w_ra];
                end
            end
        end

        assign rd[j*DATA_W +: DATA_W] = w_rd;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_regfile_mp                                                |
// | Description : Directed self-checking bench for regfile_mp at default       |
// |               parameters (32-bit, 16 regs, 3 read, 2 write ports).         |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  we;
    logic [7:0]  wa;
    logic [63:0] wd;
    logic [11:0] ra;
    logic [31:0] r15;
    logic [95:0] rd;
    logic        ready;

    int n_vec = 0;
    int n_err = 0;
    int edges;

`ifdef REGFILE_MP_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif

    regfile_mp u_dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .wa    (wa),
        .wd    (wd),
        .ra    (ra),
        .r15   (r15),
        .rd    (rd),
        .ready (ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
        ra = {a2, a1, a0};
    endtask

    task automatic wait_ready(input string tag);
        edges = 0;
        while (!ready && edges < 40) begin
            tick();
            edges++;
        end
        check_eq(tag, 32'(edges), 32'd15);
    endtask

    initial begin
        reset = 1'b1;
        we    = '0;
        wa    = '0;
        wd    = '0;
        r15   = 32'h0000_1008;
        set_ra(4'd0, 4'd1, 4'd15);
        tick();
        tick();
        check_eq("rst_ready", {31'b0, ready}, 32'd0);
        check_eq("rst_rd_pc", rd[95:64], 32'd0);

        // Sweep with writes held on R1/R2 the whole time; all must be ignored.
        reset = 1'b0;
        we    = 2'b11;
        wa    = {4'd2, 4'd1};
        wd    = {32'hBBBB_0002, 32'hAAAA_0001};
        set_ra(4'd1, 4'd2, 4'd15);
        edges = 0;
        while (!ready && edges < 40) begin
            tick();
            edges++;
            if (edges == 5) begin
                check_eq("clr_rd_pc", rd[95:64], 32'd0);
                check_eq("clr_rd_r1", rd[31:0], 32'd0);
            end
        end
        check_eq("sweep_len", 32'(edges), 32'd15);
        we = '0;

        for (int i = 0; i < 15; i++) begin
            set_ra(4'(i), 4'(14 - i), 4'd15);
            #1;
            check_eq($sformatf("clr_r%0d", i), rd[31:0], 32'd0);
        end
        check_eq("pc_read", rd[95:64], 32'h0000_1008);

        // Reset reasserted at sweep edge 7.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (7) tick();
        check_eq("mid_ready", {31'b0, ready}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_ready("resweep_len");

        // Dual write.
        we = 2'b11;
        wa = {4'd4, 4'd3};
        wd = {32'h1234_5678, 32'hDEAD_BEEF};
        tick();
        we = '0;
        set_ra(4'd3, 4'd4, 4'd15);
        #1;
        check_eq("dual_r3", rd[31:0], 32'hDEAD_BEEF);
        check_eq("dual_r4", rd[63:32], 32'h1234_5678);

        // Conflict: port1 must win.
        we = 2'b11;
        wa = {4'd5, 4'd5};
        wd = {32'h2222_2222, 32'h1111_1111};
        tick();
        we = '0;
        set_ra(4'd5, 4'd0, 4'd14);
        #1;
        check_eq("conflict_r5", rd[31:0], 32'h2222_2222);

        // PC write discarded while the other port writes R6.
        r15 = 32'h0000_2008;
        we  = 2'b11;
        wa  = {4'd6, 4'd15};
        wd  = {32'h0000_0066, 32'hFFFF_FFFF};
        tick();
        we = '0;
        set_ra(4'd15, 4'd14, 4'd6);
        #1;
        check_eq("pcw_read15", rd[31:0], 32'h0000_2008);
        check_eq("pcw_r14", rd[63:32], 32'd0);
        check_eq("pcw_r6", rd[95:64], 32'h0000_0066);
        set_ra(4'd0, 4'd3, 4'd1);
        #1;
        check_eq("pcw_r0", rd[31:0], 32'd0);
        check_eq("pcw_r3", rd[63:32], 32'hDEAD_BEEF);
        check_eq("clrw_r1", rd[95:64], 32'd0);
        set_ra(4'd2, 4'd4, 4'd5);
        #1;
        check_eq("clrw_r2", rd[31:0], 32'd0);
        check_eq("pcw_r4", rd[63:32], 32'h1234_5678);

        // Same-cycle write/read of R7.
        we = 2'b01;
        wa = {4'd0, 4'd7};
        wd = {32'h0, 32'hA5A5_A5A5};
        set_ra(4'd7, 4'd3, 4'd15);
        #1;
        check_eq("byp_r7_pre", rd[31:0], c_BYP ? 32'hA5A5_A5A5 : 32'd0);
        check_eq("byp_r3_pre", rd[63:32], 32'hDEAD_BEEF);
        tick();
        we = '0;
        #1;
        check_eq("byp_r7_post", rd[31:0], 32'hA5A5_A5A5);

        // Same-cycle conflicting writes to R8 plus a PC-targeted write read back.
        we = 2'b11;
        wa = {4'd8, 4'd8};
        wd = {32'h8888_0001, 32'h8888_0000};
        set_ra(4'd8, 4'd15, 4'd9);
        #1;
        check_eq("byp_r8_pre", rd[31:0], c_BYP ? 32'h8888_0001 : 32'd0);
        check_eq("byp_pc", rd[63:32], 32'h0000_2008);
        tick();
        we = '0;
        #1;
        check_eq("byp_r8_post", rd[31:0], 32'h8888_0001);
        check_eq("byp_r9", rd[95:64], 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
